mem_port_arbiter: RTL and testbench

- Arbitrates one single-port unified instruction/data memory between the fetch stage (F) and the memory stage (M) of the 5-stage MIPS pipeline.
- Sequences each multi-cycle memory access and returns read data with a one-cycle valid pulse.
- Drives Stall_F/Stall_M into the pipeline stall logic, alongside the load-use and branch hazard stalls.

---
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch vs. memory stage, multi-cycle access.
// Optional stall-cycle counters enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Req_F,
    input  logic [ADDR_W-1:0] Addr_F,
    input  logic              Flush_F,
    input  logic              Req_M,
    input  logic              We_M,
    input  logic [ADDR_W-1:0] Addr_M,
    input  logic [DATA_W-1:0] WData_M,
    output logic              Mem_En,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData,
    output logic [DATA_W-1:0] RData_F,
    output logic              Valid_F,
    output logic [DATA_W-1:0] RData_M,
    output logic              Valid_M,
    output logic              Stall_F,
    output logic              Stall_M,
    output logic [31:0]       Cnt_Stall_F,
    output logic [31:0]       Cnt_Stall_M
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_F,
        BUSY_M
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              kill_q, kill_d;
    logic              last_m_q, last_m_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_f_q, rdata_f_d;
    logic [DATA_W-1:0] rdata_m_q, rdata_m_d;
    logic              valid_f_q, valid_f_d;
    logic              valid_m_q, valid_m_d;

    logic done, killed, fin_f, fin_m;
    logic elig_f, elig_m, free, gnt_f, gnt_m;

    always_comb begin
        done   = (state_q != IDLE) && (cnt_q == CNT_LAST);
        killed = kill_q | Flush_F;
        fin_f  = done && (state_q == BUSY_F);
        fin_m  = done && (state_q == BUSY_M);
        // A killed fetch frees the port for the redirected fetch at once.
        elig_f = Req_F && !(fin_f && !killed) && !valid_f_q;
        elig_m = Req_M && !fin_m && !valid_m_q;
        free   = (state_q == IDLE) || done;
        gnt_m  = free && elig_m && !(elig_f && last_m_q);
        gnt_f  = free && elig_f && !gnt_m;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kill_d    = kill_q;
        last_m_d  = last_m_q;
        en_d      = en_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_f_d = rdata_f_q;
        rdata_m_d = rdata_m_q;
        valid_f_d = 1'b0;
        valid_m_d = 1'b0;

        if (state_q == BUSY_F && Flush_F) begin
            kill_d = 1'b1;
        end

        if (state_q != IDLE && !done) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (fin_f) begin
            kill_d = 1'b0;
            if (!killed) begin
                valid_f_d = 1'b1;
                rdata_f_d = Mem_RData;
            end
        end

        if (fin_m) begin
            valid_m_d = 1'b1;
            if (!we_q) begin
                rdata_m_d = Mem_RData;
            end
        end

        if (done) begin
            state_d = IDLE;
            en_d    = 1'b0;
            we_d    = 1'b0;
        end

        unique case (1'b1)
            gnt_m: begin
                state_d  = BUSY_M;
                cnt_d    = '0;
                en_d     = 1'b1;
                we_d     = We_M;
                addr_d   = Addr_M;
                wdata_d  = WData_M;
                last_m_d = 1'b1;
            end
            gnt_f: begin
                state_d  = BUSY_F;
                cnt_d    = '0;
                en_d     = 1'b1;
                we_d     = 1'b0;
                addr_d   = Addr_F;
                wdata_d  = '0;
                last_m_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            kill_q    <= 1'b0;
            last_m_q  <= 1'b0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_f_q <= '0;
            rdata_m_q <= '0;
            valid_f_q <= 1'b0;
            valid_m_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kill_q    <= kill_d;
            last_m_q  <= last_m_d;
            en_q      <= en_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_f_q <= rdata_f_d;
            rdata_m_q <= rdata_m_d;
            valid_f_q <= valid_f_d;
            valid_m_q <= valid_m_d;
        end
    end

    assign Mem_En    = en_q;
    assign Mem_We    = we_q;
    assign Mem_Addr  = addr_q;
    assign Mem_WData = wdata_q;
    assign RData_F   = rdata_f_q;
    assign RData_M   = rdata_m_q;
    assign Valid_F   = valid_f_q;
    assign Valid_M   = valid_m_q;
    assign Stall_F   = Req_F & ~valid_f_q;
    assign Stall_M   = Req_M & ~valid_m_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] cnt_sf_q, cnt_sm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_sf_q <= '0;
            cnt_sm_q <= '0;
        end else begin
            if (Stall_F) cnt_sf_q <= cnt_sf_q + 32'd1;
            if (Stall_M) cnt_sm_q <= cnt_sm_q + 32'd1;
        end
    end

    assign Cnt_Stall_F = cnt_sf_q;
    assign Cnt_Stall_M = cnt_sm_q;
`else
    assign Cnt_Stall_F = 32'd0;
    assign Cnt_Stall_M = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle vector table plus read-data scoreboard.
// Counter checks follow MEM_ARB_PERF_EN.
module tb_mem_port_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        rst_n;
    logic        Req_F, Flush_F, Req_M, We_M;
    logic [31:0] Addr_F, Addr_M, WData_M;
    logic        Mem_En, Mem_We;
    logic [31:0] Mem_Addr, Mem_WData, Mem_RData;
    logic [31:0] RData_F, RData_M;
    logic        Valid_F, Valid_M, Stall_F, Stall_M;
    logic [31:0] Cnt_Stall_F, Cnt_Stall_M;

    mem_port_arbiter #(
        .MEM_LAT(2),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Req_F      (Req_F),
        .Addr_F     (Addr_F),
        .Flush_F    (Flush_F),
        .Req_M      (Req_M),
        .We_M       (We_M),
        .Addr_M     (Addr_M),
        .WData_M    (WData_M),
        .Mem_En     (Mem_En),
        .Mem_We     (Mem_We),
        .Mem_Addr   (Mem_Addr),
        .Mem_WData  (Mem_WData),
        .Mem_RData  (Mem_RData),
        .RData_F    (RData_F),
        .Valid_F    (Valid_F),
        .RData_M    (RData_M),
        .Valid_M    (Valid_M),
        .Stall_F    (Stall_F),
        .Stall_M    (Stall_M),
        .Cnt_Stall_F(Cnt_Stall_F),
        .Cnt_Stall_M(Cnt_Stall_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C01_0004 : ~a;
    endfunction

    assign Mem_RData = Mem_En ? rd(Mem_Addr) : 32'h0;

    typedef struct {
        logic        rf;
        logic [31:0] af;
        logic        fl;
        logic        rm;
        logic        wm;
        logic [31:0] am;
        logic [31:0] wd;
        logic        en;
        logic        we;
        logic [31:0] ea;
        logic [31:0] ew;
        logic        vf;
        logic        vm;
        logic        sf;
        logic        sm;
        logic        pf;
        logic        pm;
    } row_t;

    function automatic row_t R(
        input logic rf, input logic [31:0] af, input logic fl,
        input logic rm, input logic wm, input logic [31:0] am,
        input logic [31:0] wd,
        input logic en, input logic we, input logic [31:0] ea,
        input logic [31:0] ew,
        input logic vf, input logic vm, input logic sf, input logic sm,
        input logic pf, input logic pm);
        row_t r;
        r.rf = rf; r.af = af; r.fl = fl;
        r.rm = rm; r.wm = wm; r.am = am; r.wd = wd;
        r.en = en; r.we = we; r.ea = ea; r.ew = ew;
        r.vf = vf; r.vm = vm; r.sf = sf; r.sm = sm;
        r.pf = pf; r.pm = pm;
        return r;
    endfunction

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] qf[$];
    logic [31:0] qm[$];
    logic [31:0] last_ld = 32'h0;
    logic [31:0] exp_cf = 32'h0;
    logic [31:0] exp_cm = 32'h0;
    row_t        pre[$];
    row_t        post[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_cnt();
`ifdef MEM_ARB_PERF_EN
        chk("Cnt_Stall_F", Cnt_Stall_F, exp_cf);
        chk("Cnt_Stall_M", Cnt_Stall_M, exp_cm);
`else
        chk("Cnt_Stall_F", Cnt_Stall_F, 32'h0);
        chk("Cnt_Stall_M", Cnt_Stall_M, 32'h0);
`endif
    endtask

    task automatic apply_row(input row_t r);
        @(negedge clk);
        Req_F   = r.rf;
        Addr_F  = r.af;
        Flush_F = r.fl;
        Req_M   = r.rm;
        We_M    = r.wm;
        Addr_M  = r.am;
        WData_M = r.wd;
        if (r.pf) qf.push_back(rd(r.af));
        if (r.pm) begin
            if (!r.wm) last_ld = rd(r.am);
            qm.push_back(last_ld);
        end
        #1;
        chk1("Mem_En", Mem_En, r.en);
        chk1("Mem_We", Mem_We, r.we);
        if (r.en) begin
            chk("Mem_Addr", Mem_Addr, r.ea);
            chk("Mem_WData", Mem_WData, r.ew);
        end
        chk1("Valid_F", Valid_F, r.vf);
        chk1("Valid_M", Valid_M, r.vm);
        chk1("Stall_F", Stall_F, r.sf);
        chk1("Stall_M", Stall_M, r.sm);
        chk_cnt();
        if (Valid_F) begin
            if (qf.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_F @%0t: Valid_F with none expected", $time);
            end else begin
                chk("RData_F", RData_F, qf.pop_front());
            end
        end
        if (Valid_M) begin
            if (qm.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_M @%0t: Valid_M with none expected", $time);
            end else begin
                chk("RData_M", RData_M, qm.pop_front());
            end
        end
        exp_cf += {31'b0, r.sf};
        exp_cm += {31'b0, r.sm};
    endtask

    initial begin
        // fetch 0x40
        pre.push_back(R(L,0,L,L,L,0,0, L,L,0,0, L,L,L,L, L,L));
        pre.push_back(R(H,32'h40,L,L,L,0,0, L,L,0,0, L,L,H,L, H,L));
        pre.push_back(R(H,32'h40,L,L,L,0,0, H,L,32'h40,0, L,L,H,L, L,L));
        pre.push_back(R(H,32'h40,L,L,L,0,0, H,L,32'h40,0, L,L,H,L, L,L));
        pre.push_back(R(H,32'h40,L,L,L,0,0, L,L,0,0, H,L,L,L, L,L));
        // F and M together, M first, no bubble
        pre.push_back(R(H,32'h44,L,H,L,32'h100,0, L,L,0,0, L,L,H,H, H,H));
        pre.push_back(R(H,32'h44,L,H,L,32'h100,0, H,L,32'h100,0, L,L,H,H, L,L));
        pre.push_back(R(H,32'h44,L,H,L,32'h100,0, H,L,32'h100,0, L,L,H,H, L,L));
        pre.push_back(R(H,32'h44,L,H,L,32'h100,0, H,L,32'h44,0, L,H,H,L, L,L));
        pre.push_back(R(H,32'h44,L,L,L,0,0, H,L,32'h44,0, L,L,H,L, L,L));
        pre.push_back(R(H,32'h44,L,L,L,0,0, L,L,0,0, H,L,L,L, L,L));
        pre.push_back(R(L,0,L,L,L,0,0, L,L,0,0, L,L,L,L, L,L));
        // store, inputs wiggle while busy
        pre.push_back(R(L,0,L,H,H,32'h200,32'hDEADBEEF,
                        L,L,0,0, L,L,L,H, L,H));
        pre.push_back(R(L,0,L,H,H,32'h204,32'h12345678,
                        H,H,32'h200,32'hDEADBEEF, L,L,L,H, L,L));
        pre.push_back(R(L,0,L,H,H,32'h204,32'h12345678,
                        H,H,32'h200,32'hDEADBEEF, L,L,L,H, L,L));
        pre.push_back(R(L,0,L,H,H,32'h204,32'h12345678,
                        L,L,0,0, L,H,L,L, L,L));
        pre.push_back(R(L,0,L,L,L,0,0, L,L,0,0, L,L,L,L, L,L));
        // flush during fetch, redirect to 0x80
        pre.push_back(R(H,32'h40,L,L,L,0,0, L,L,0,0, L,L,H,L, L,L));
        pre.push_back(R(H,32'h40,L,L,L,0,0, H,L,32'h40,0, L,L,H,L, L,L));
        pre.push_back(R(H,32'h80,H,L,L,0,0, H,L,32'h40,0, L,L,H,L, H,L));
        pre.push_back(R(H,32'h80,L,L,L,0,0, H,L,32'h80,0, L,L,H,L, L,L));
        pre.push_back(R(H,32'h80,L,L,L,0,0, H,L,32'h80,0, L,L,H,L, L,L));
        pre.push_back(R(H,32'h80,H,L,L,0,0, L,L,0,0, H,L,L,L, L,L));
        pre.push_back(R(L,0,H,L,L,0,0, L,L,0,0, L,L,L,L, L,L));
        pre.push_back(R(L,0,L,L,L,0,0, L,L,0,0, L,L,L,L, L,L));
        // continuous requests alternate M,F,M,F
        pre.push_back(R(H,32'h300,L,H,L,32'h400,0, L,L,0,0, L,L,H,H, H,H));
        pre.push_back(R(H,32'h300,L,H,L,32'h400,0, H,L,32'h400,0, L,L,H,H, L,L));
        pre.push_back(R(H,32'h300,L,H,L,32'h400,0, H,L,32'h400,0, L,L,H,H, L,L));
        pre.push_back(R(H,32'h300,L,H,L,32'h400,0, H,L,32'h300,0, L,H,H,L, L,H));
        pre.push_back(R(H,32'h300,L,H,L,32'h400,0, H,L,32'h300,0, L,L,H,H, L,L));
        pre.push_back(R(H,32'h300,L,H,L,32'h400,0, H,L,32'h400,0, H,L,L,H, H,L));
        pre.push_back(R(H,32'h300,L,H,L,32'h400,0, H,L,32'h400,0, L,L,H,H, L,L));
        pre.push_back(R(H,32'h300,L,H,L,32'h400,0, H,L,32'h300,0, L,H,H,L, L,L));
        pre.push_back(R(H,32'h300,L,L,L,0,0, H,L,32'h300,0, L,L,H,L, L,L));
        pre.push_back(R(H,32'h300,L,L,L,0,0, L,L,0,0, H,L,L,L, L,L));
        pre.push_back(R(L,0,L,L,L,0,0, L,L,0,0, L,L,L,L, L,L));
        // after the mid-access reset
        post.push_back(R(L,0,L,L,L,0,0, L,L,0,0, L,L,L,L, L,L));
        post.push_back(R(L,0,L,H,L,32'h600,0, L,L,0,0, L,L,L,H, L,H));
        post.push_back(R(L,0,L,H,L,32'h600,0, H,L,32'h600,0, L,L,L,H, L,L));
        post.push_back(R(L,0,L,H,L,32'h600,0, H,L,32'h600,0, L,L,L,H, L,L));
        post.push_back(R(L,0,L,H,L,32'h600,0, L,L,0,0, L,H,L,L, L,L));
        post.push_back(R(L,0,L,L,L,0,0, L,L,0,0, L,L,L,L, L,L));

        rst_n = 1'b0;
        Req_F = 1'b0; Addr_F = '0; Flush_F = 1'b0;
        Req_M = 1'b0; We_M = 1'b0; Addr_M = '0; WData_M = '0;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst Mem_En", Mem_En, 1'b0);
        chk1("rst Mem_We", Mem_We, 1'b0);
        chk("rst Mem_Addr", Mem_Addr, 32'h0);
        chk("rst Mem_WData", Mem_WData, 32'h0);
        chk("rst RData_F", RData_F, 32'h0);
        chk("rst RData_M", RData_M, 32'h0);
        chk1("rst Valid_F", Valid_F, 1'b0);
        chk1("rst Valid_M", Valid_M, 1'b0);
        chk_cnt();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < pre.size(); i++) apply_row(pre[i]);

        // load at 0x500 abandoned by reset in its first busy cycle
        apply_row(R(L,0,L,H,L,32'h500,0, L,L,0,0, L,L,L,H, L,L));
        apply_row(R(L,0,L,H,L,32'h500,0, H,L,32'h500,0, L,L,L,H, L,L));
        #2;
        rst_n = 1'b0;
        exp_cf = 32'h0;
        exp_cm = 32'h0;
        last_ld = 32'h0;
        #1;
        chk1("arst Mem_En", Mem_En, 1'b0);
        chk1("arst Mem_We", Mem_We, 1'b0);
        chk1("arst Valid_M", Valid_M, 1'b0);
        chk1("arst Valid_F", Valid_F, 1'b0);
        chk1("arst Stall_M", Stall_M, 1'b1);
        chk("arst RData_M", RData_M, 32'h0);
        chk_cnt();
        @(posedge clk);
        @(negedge clk);
        Req_M = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < post.size(); i++) apply_row(post[i]);

        chk("sb_F left", qf.size(), 32'h0);
        chk("sb_M left", qm.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
